seq_exec_unit: RTL

SEQ_EXEC_UNIT -- requirements
Module: seq_exec_unit

---
 rtl/exec_pkg.sv | 32 +++
 rtl/seq_multiplier.sv | 60 ++++++
 rtl/seq_exec_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared types for the sequential execution unit: opcode and FSM state
// encodings plus the bit positions of the {Z,N,C,V} flag vector.
package exec_pkg;

    typedef enum logic [2:0] {
        OP_LDI  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_MUL  = 3'b011,
        OP_IMUL = 3'b100,
        OP_AND  = 3'b101,
        OP_XOR  = 3'b110,
        OP_CMP  = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MULT = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    function automatic logic is_mul_op(input op_t op);
        return (op == OP_MUL) || (op == OP_IMUL);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle over the
// operand magnitudes, with the sign restored on the final product.
// busy rises on the start edge and falls after DW steps; result is then
// stable until the next start.
module seq_multiplier #(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_signed,
    input  logic [DW-1:0]     a,
    input  logic [DW-1:0]     b,
    output logic              busy,
    output logic [2*DW-1:0]   result
);

    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0]   mcand;
    logic [2*DW-1:0] prod;
    logic            neg;
    logic [CW-1:0]   step;
    logic [DW:0]     sum;

    function automatic logic [DW-1:0] mag(input logic [DW-1:0] x, input logic s);
        return (s && x[DW-1]) ? (DW'(0) - x) : x;
    endfunction

    // Upper half plus the multiplicand when the current multiplier bit is set.
    always_comb begin
        sum = {1'b0, prod[2*DW-1:DW]} + {1'b0, (prod[0] ? mcand : '0)};
    end

    // Load magnitudes on start, then add-and-shift right once per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            prod  <= '0;
            neg   <= 1'b0;
            step  <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            mcand <= mag(a, is_signed);
            prod  <= {{DW{1'b0}}, mag(b, is_signed)};
            neg   <= is_signed && (a[DW-1] ^ b[DW-1]);
            step  <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            prod <= {sum, prod[DW-1:1]};
            step <= step + 1'b1;
            if (step == CW'(DW - 1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign result = neg ? ((2*DW)'(0) - prod) : prod;

endmodule

// File: rtl/seq_exec_unit.sv
// Sequential execution unit: single-issue register machine with an ALU
// retiring in one cycle and an optional multi-cycle multiplier.
// Build option: define EXEC_MUL_EN to implement MUL/IMUL; otherwise both
// opcodes retire as illegal with no register or flag update.
module seq_exec_unit
    import exec_pkg::*;
#(
    parameter int  DW    = 8,
    parameter int  NREGS = 8,
    localparam int RW    = $clog2(NREGS),
    localparam int IW    = 3 + 3*RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] instr,
    output logic          done,
    output logic          illegal,
    output logic [3:0]    flags,
    input  logic [RW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    state_t state_q, state_d;

    logic [DW-1:0] regs [NREGS];

    op_t           in_op;
    logic [RW-1:0] in_rd, in_rs1, in_rs2;
    logic          accept;

    op_t             op_q;
    logic [RW-1:0]   rd_q;
    logic [DW-1:0]   a_q, b_q;
    logic [2*RW-1:0] imm_q;
    logic [DW-1:0]   imm_ext;

    logic [DW:0]   sum_w, diff_w;
    logic [DW-1:0] res;
    logic          wr_en, fl_en, done_d, ill_d;
    logic          c_f, v_f, cmp;
    logic [3:0]    fl_d;

`ifdef EXEC_MUL_EN
    localparam int CW = $clog2(DW + 1);
    logic [CW-1:0]   cnt_q;
    logic            mul_start, mul_busy;
    logic [2*DW-1:0] mul_result;
    logic [DW-1:0]   mul_hi;
`endif

    assign in_op  = op_t'(instr[IW-1 -: 3]);
    assign in_rd  = instr[3*RW-1:2*RW];
    assign in_rs1 = instr[2*RW-1:RW];
    assign in_rs2 = instr[RW-1:0];

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;

    assign imm_ext = DW'(imm_q);
    assign sum_w   = {1'b0, a_q} + {1'b0, b_q};
    assign diff_w  = {1'b0, a_q} - {1'b0, b_q};

    assign dbg_data = regs[dbg_addr];

`ifdef EXEC_MUL_EN
    assign mul_start = accept && is_mul_op(in_op);
    assign mul_hi    = mul_result[2*DW-1:DW];

    seq_multiplier #(
        .DW (DW)
    ) u_mult (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_start),
        .is_signed (in_op == OP_IMUL),
        .a         (regs[in_rs1]),
        .b         (regs[in_rs2]),
        .busy      (mul_busy),
        .result    (mul_result)
    );

    // Cycle counter pacing the stay in MULT to exactly DW cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == S_MULT) begin
            cnt_q <= (cnt_q == CW'(DW - 1)) ? '0 : cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, ALU result, flag computation and retirement controls.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        ill_d   = 1'b0;
        wr_en   = 1'b0;
        fl_en   = 1'b0;
        res     = '0;
        c_f     = 1'b0;
        v_f     = 1'b0;
        cmp     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
`ifdef EXEC_MUL_EN
                    state_d = is_mul_op(in_op) ? S_MULT : S_EXEC;
`else
                    state_d = S_EXEC;
`endif
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                wr_en   = 1'b1;
                fl_en   = 1'b1;
                case (op_q)
                    OP_LDI: res = imm_ext;
                    OP_ADD: begin
                        res = sum_w[DW-1:0];
                        c_f = sum_w[DW];
                        v_f = (a_q[DW-1] == b_q[DW-1]) && (sum_w[DW-1] != a_q[DW-1]);
                    end
                    OP_SUB: begin
                        res = diff_w[DW-1:0];
                        c_f = diff_w[DW];
                        v_f = (a_q[DW-1] != b_q[DW-1]) && (diff_w[DW-1] != a_q[DW-1]);
                    end
                    OP_AND: res = a_q & b_q;
                    OP_XOR: res = a_q ^ b_q;
                    OP_CMP: begin
                        wr_en = 1'b0;
                        cmp   = 1'b1;
                    end
                    // Multiply opcodes only reach EXEC when no multiplier is built.
                    default: begin
                        wr_en = 1'b0;
                        fl_en = 1'b0;
                        ill_d = 1'b1;
                    end
                endcase
            end
`ifdef EXEC_MUL_EN
            S_MULT: begin
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (!mul_busy) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    wr_en   = 1'b1;
                    fl_en   = 1'b1;
                    res     = mul_result[DW-1:0];
                    v_f     = (op_q == OP_IMUL) ? (mul_hi != {DW{mul_result[DW-1]}})
                                                : (mul_hi != '0);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        fl_d         = '0;
        fl_d[FLAG_Z] = cmp ? (a_q == b_q) : (res == '0);
        fl_d[FLAG_N] = cmp ? ($signed(a_q) < $signed(b_q)) : res[DW-1];
        fl_d[FLAG_C] = cmp ? (a_q < b_q) : c_f;
        fl_d[FLAG_V] = v_f;
    end

    // Instruction capture at accept, flag register and retirement pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_LDI;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            flags   <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done    <= done_d;
            illegal <= ill_d;
            if (accept) begin
                op_q  <= in_op;
                rd_q  <= in_rd;
                a_q   <= regs[in_rs1];
                b_q   <= regs[in_rs2];
                imm_q <= {in_rs1, in_rs2};
            end
            if (fl_en) begin
                flags <= fl_d;
            end
        end
    end

    // Register file write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rd_q] <= res;
        end
    end

endmodule
